gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Registered up/down counter that keeps a binary count and presents the matching Gray code on a registered output.
- Produces the Gray sequences that the team's Gray-to-binary converters consume, for example pointer generation and encoder test sources.
- Provides synchronous load, a hold-enable, a registered wrap flag, and an optional adjacency checker.

Parameters:
- WIDTH, 4, count width in bits for both the binary and Gray outputs (minimum 2).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; the count advances one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe; has priority over en.
- load_bin  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin: gray = bin ^ (bin >> 1).
- tc  output  1  registered terminal-count (wrap) flag.
- err  output  1  sticky adjacency-error flag; present only with GRAY_CHECK_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - bin=0, gray=0, tc=0, err=0.
  - Overrides load and en.
  - Takes effect at the next edge whatever operation is in flight.
- Priority per edge: rst > load > en > hold.
- Load:
  - bin <= load_bin and gray <= load_bin ^ (load_bin >> 1), both on the same edge.
  - tc <= 0.
  - No step is taken, even if en=1 in the same cycle.
- Step (en=1, load=0):
  - up_dn=1: bin <= bin + 1 modulo 2^WIDTH.
  - up_dn=0: bin <= bin - 1 modulo 2^WIDTH.
  - Gray is computed combinationally from next_bin and registered on the same edge as bin. gray never lags bin; latency from en to both outputs is 1 cycle.
- Wrap:
  - tc=1 for exactly one cycle after the edge where the count wraps: up from all-ones to 0, or down from 0 to all-ones.
  - tc=0 after every other step, hold, or load.
- Hold (en=0, load=0): bin, gray and err are unchanged; tc <= 0.
- Direction change: takes effect on the next enabled step with no bubble. Alternating up_dn yields alternating values (e.g. 5,4,5,4).
- Invariants after any edge:
  - gray always equals bin ^ (bin >> 1).
  - Consecutive stepped values differ in exactly one Gray bit, including across the wrap.
- State machine: implicit; the only state is the bin register (plus the tc and err flags). There are no idle or busy states, so every cycle accepts a command.

Optional Feature:
- Macro name: GRAY_CHECK_EN.
- When defined:
  - Internal previous-gray register and a comparator.
  - After each enabled step (not a load, not reset), if the popcount of (gray_prev ^ gray) is not 1, err is set to 1.
  - err is sticky until rst.
  - The err port exists.
- When undefined: the comparator, the previous-gray register and the err port are all absent. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - DIR_UP = 1'b1 and DIR_DN = 1'b0 direction constants.
  - Default count-width constant (4).
- Sub-module bin_to_gray:
  - Combinational, parameter WIDTH; output = input ^ (input >> 1).
  - Instantiated on next_bin inside the counter.
  - Reusable by the team's encoders.

Test Plan:
- Up sweep: rst 2 cycles, then en=1, up_dn=1 for 16 cycles.
  - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - tc=1 only on the 0000 cycle.
  - Bench decodes gray to binary every cycle and compares it with bin.
- Down wrap: from reset, en=1, up_dn=0 for one cycle.
  - bin=1111, gray=1000, tc=1.
  - Next down step gives bin=1110, gray=1001, tc=0.
- Load vs en: load=1, load_bin=1010, en=1, up_dn=1 in the same cycle.
  - bin=1010, gray=1111, tc=0, no increment.
  - Next enabled up step gives bin=1011, gray=1110.
- Hold: at bin=0110, en=0 for 5 cycles.
  - bin=0110 and gray=0101 stay constant; tc=0 throughout.
- Reset mid-operation: at bin=0111, assert rst together with load=1, load_bin=1100, en=1.
  - Next edge gives bin=0000, gray=0000, tc=0 (and err=0).
- Checker (GRAY_CHECK_EN defined): 200 cycles of random en/up_dn with loads interleaved.
  - err stays 0.
  - Forcing the internal gray register to flip 2 bits for one cycle sets err=1, which holds until rst.

Source files
------------

// File: rtl/gray_code_counter_pkg.sv
// Shared constants for the Gray code counter and its bin_to_gray helper.
// Optional adjacency checker in the counter is enabled by defining GRAY_CHECK_EN.
package gray_code_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;

endpackage : gray_code_counter_pkg

// File: rtl/gray_code_counter_bin_to_gray.sv
// Binary to reflected-Gray conversion, purely combinational (zero latency).
// No flow control; reusable by encoders and pointer logic.
module bin_to_gray #(
  parameter int WIDTH = gray_code_counter_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule : bin_to_gray

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray output, sync load, hold and wrap flag; 1-cycle latency, accepts a command every cycle.
// Optional sticky adjacency checker and err port when GRAY_CHECK_EN is defined.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
`ifdef GRAY_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             step;

  // Priority below reset: load, then step, then hold.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    step  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      step = 1'b1;
      if (up_dn == DIR_UP) begin
        bin_d = bin_q + ONE;
        tc_d  = &bin_q;
      end else begin
        bin_d = bin_q - ONE;
        tc_d  = ~|bin_q;
      end
    end
  end

  // Gray is derived from next_bin so it is registered on the same edge as bin.
  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_q;

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  // Compare the registered gray against its value before the last step.
  always_comb begin
    gray_prev_d = gray_q;
    step_d      = step;
    err_d       = err_q;
    if (step_q && ($countones(gray_q ^ gray_prev_q) != 1)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_prev_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_prev_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule : gray_code_counter

// File: tb/tb_gray_code_counter.sv
// Randomised + directed scoreboard bench for gray_code_counter.
// Covers the adjacency checker when built with GRAY_CHECK_EN.
module tb_gray_code_counter;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         tc;
    logic         err;
    logic         stepped;
    logic         skip_gray;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         tc;
  logic         err_w;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  int model_bin = 0;
  logic model_err = 1'b0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .tc       (tc)
`ifdef GRAY_CHECK_EN
    ,
    .err      (err_w)
`endif
  );

`ifndef GRAY_CHECK_EN
  assign err_w = 1'b0;
`endif

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W-1:0] gray_decode(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // One command per cycle; the expected post-edge state is queued for the monitor.
  task automatic cycle(input logic r, input logic ld, input logic [W-1:0] lb,
                       input logic e, input logic u, input logic skip);
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; load_bin = lb; en = e; up_dn = u;
    x.tc = 1'b0;
    x.stepped = 1'b0;
    if (r) begin
      model_bin = 0;
      model_err = 1'b0;
    end else if (ld) begin
      model_bin = int'(lb);
    end else if (e) begin
      x.stepped = 1'b1;
      if (u) begin
        x.tc = (model_bin == MOD - 1);
        model_bin = (model_bin + 1) % MOD;
      end else begin
        x.tc = (model_bin == 0);
        model_bin = (model_bin + MOD - 1) % MOD;
      end
    end
    x.bin = W'(model_bin);
    x.gray = to_gray(model_bin);
    x.err = model_err;
    x.skip_gray = skip;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic [W-1:0] prev_gray;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("bin", bin, x.bin);
        check("tc", W'(tc), W'(x.tc));
        check("err", W'(err_w), W'(x.err));
        if (!x.skip_gray) begin
          check("gray", gray, x.gray);
          check("gray_decode", gray_decode(gray), bin);
          if (x.stepped) check("one_bit_step", W'($countones(gray ^ prev_gray)), W'(1));
        end
      end
      prev_gray = gray;
    end
  end

  initial begin : driver
    logic [W-1:0] g_before, g_after, mask;
    int cnt;
    // Reset, then full up sweep through the wrap.
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 1, 0);
    // Down wrap from reset.
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Load beats en, then step up.
    cycle(0, 1, 4'b1010, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    // Direction alternation without bubbles.
    cycle(0, 1, 4'd5, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i[0], 0);
    // Hold.
    cycle(0, 1, 4'b0110, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
    // Reset wins over load and en.
    cycle(0, 1, 4'b0111, 0, 1, 0);
    cycle(1, 1, 4'b1100, 1, 1, 0);
    // Random traffic with interleaved loads.
    for (int i = 0; i < 200; i++) begin
      cycle(0, ($urandom_range(7) == 0), W'($urandom_range(MOD - 1)),
            $urandom_range(1) == 1, $urandom_range(1) == 1, 0);
    end
`ifdef GRAY_CHECK_EN
    // Corrupt the gray register right after a step; err must latch until reset.
    g_before = to_gray(model_bin);
    cycle(0, 0, 0, 1, 1, 0);
    g_after = to_gray(model_bin);
    @(posedge clk);
    #2;
    mask = '0;
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (!(g_before[i] ^ g_after[i]) && cnt < 2) begin
        mask[i] = 1'b1;
        cnt++;
      end
    end
    force dut.gray_q = g_after ^ mask;
    model_err = 1'b1;
    cycle(0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #2;
    release dut.gray_q;
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
`endif
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gray_code_counter
